// File: rtl/switch_alloc_rr_if.sv
// Switch allocator bundle: requests and credit returns in,
// grants, crossbar selects and credit state out.
interface switch_alloc_rr_if #(
  parameter int N            = 5,
  parameter int M            = 5,
  parameter int CREDIT_DEPTH = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic [0:N-1][0:M-1]   i_output_req;
  logic [0:M-1]          i_credit_return;
  logic [0:N-1][0:M-1]   o_grant;
  logic [0:N-1]          o_input_ack;
  logic [0:M-1]          o_output_val;
  logic [0:M-1][SW-1:0]  o_input_sel;
  logic [0:M-1][CW-1:0]  o_credits;
  logic                  o_credit_err;

  modport master (
    output i_output_req, i_credit_return,
    input  o_grant, o_input_ack, o_output_val,
    input  o_input_sel, o_credits, o_credit_err
  );

  modport slave (
    input  i_output_req, i_credit_return,
    output o_grant, o_input_ack, o_output_val,
    output o_input_sel, o_credits, o_credit_err
  );
endinterface

// File: rtl/switch_alloc_rr.sv
// Round-robin switch allocator with per-output credits.
// Ports: clk, reset (async high), bus (slave: req/return in, grant/sel/credits out).
module switch_alloc_rr #(
  parameter int N            = 5,
  parameter int M            = 5,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  switch_alloc_rr_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic [0:M-1][SW-1:0] ptr;
  logic [0:M-1][CW-1:0] credits;
  logic                 err;

  logic [0:N-1][0:M-1]  req_c;
  logic [0:N-1][0:M-1]  grant;
  logic [0:M-1]         val;
  logic [0:M-1][SW-1:0] sel;

  // Keep only the lowest-index set bit.
  function automatic logic [0:M-1] lowest(
    input logic [0:M-1] r
  );
    logic [0:M-1] l;
    l = '0;
    for (int m = M - 1; m >= 0; m--) begin
      if (r[m]) begin
        l    = '0;
        l[m] = 1'b1;
      end
    end
    return l;
  endfunction

  always_comb begin
    int idx;
    req_c = '0;
    grant = '0;
    val   = '0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      req_c[i] = lowest(bus.i_output_req[i]);
    end
    for (int m = 0; m < M; m++) begin
      // Scan downward so the last hit is the one
      // closest to ptr in cyclic order.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr[m]) + k;
        if (idx >= N) idx = idx - N;
        if (req_c[idx][m]) begin
          val[m] = 1'b1;
          sel[m] = SW'(idx);
        end
      end
      if (credits[m] == '0) begin
        val[m] = 1'b0;
        sel[m] = '0;
      end
      if (val[m]) grant[sel[m]][m] = 1'b1;
    end
  end

  always_comb begin
    bus.o_grant      = reset ? '0 : grant;
    bus.o_output_val = reset ? '0 : val;
    bus.o_input_sel  = reset ? '0 : sel;
    bus.o_input_ack  = '0;
    for (int i = 0; i < N; i++) begin
      bus.o_input_ack[i] = ~reset & (|grant[i]);
    end
  end

  assign bus.o_credits    = credits;
  assign bus.o_credit_err = err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < M; m++) begin
        ptr[m]     <= '0;
        credits[m] <= CW'(CREDIT_DEPTH);
      end
      err <= 1'b0;
    end else begin
      for (int m = 0; m < M; m++) begin
        if (val[m]) begin
          ptr[m] <= (sel[m] == SW'(N - 1)) ?
                    '0 : sel[m] + SW'(1);
        end
        unique case ({val[m], bus.i_credit_return[m]})
          2'b10: begin
            if (credits[m] == '0) err <= 1'b1;
            else credits[m] <= credits[m] - CW'(1);
          end
          2'b01: begin
            if (credits[m] == CW'(CREDIT_DEPTH))
              err <= 1'b1;
            else
              credits[m] <= credits[m] + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule
